// File: rtl/bit_serial_adder.sv
// Bit-serial N-bit adder: one full-adder cell processes the operands LSB first,
// one bit per clock, with a start/busy/done handshake toward the operand source.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module bit_serial_adder #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic [1:0]   dbg_state
);
  // Handshake: start is accepted on a rising edge when the adder is not in RUN
  // (IDLE or FIN); done is high for exactly the one cycle spent in FIN, and
  // sum/cout are valid from that cycle until the next completion.
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   sa, sb, res, res_nxt;
  logic           carry, fa_s, fa_co;
  logic [CW-1:0]  cnt;
  logic           last, load;

  full_adder u_fa (
    .a  (sa[0]),
    .b  (sb[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // Sum bits enter at the MSB so the first (LSB) bit lands at position 0 after N shifts.
  generate
    if (N == 1) begin : g_res1
      assign res_nxt = fa_s;
    end else begin : g_resn
      assign res_nxt = {fa_s, res[N-1:1]};
    end
  endgenerate

  assign last = (cnt == CW'(N - 1));
  assign load = start && (state != RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = FIN;
      FIN:     state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (load) begin
      sa    <= a;
      sb    <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      sa    <= sa >> 1;
      sb    <= sb >> 1;
      carry <= fa_co;
      res   <= res_nxt;
      cnt   <= cnt + CW'(1);
      if (last) begin
        sum  <= res_nxt;
        cout <= fa_co;
      end
    end
  end

  assign busy      = (state == RUN);
  assign done      = (state == FIN);
  assign dbg_state = state;
endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed bench for bit_serial_adder: an N=8 instance for handshake/latency
// vectors and an N=4 instance swept over every {a,b,cin} combination.

module tb_bit_serial_adder;
  logic       clk;
  logic       rst_n;

  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic [1:0] dbg8;

  logic       start4, cin4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;
  logic [1:0] dbg4;

  int compared   = 0;
  int mismatched = 0;

  bit_serial_adder #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .dbg_state(dbg8)
  );

  bit_serial_adder #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .dbg_state(dbg4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: present operands with start, then drop start one cycle later.
  task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic c);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check("busy_after_start8", 32'(busy8), 32'd1);
  endtask

  // Entered one negedge after the accepting edge; returns at the negedge where done is high.
  task automatic finish8(input string tag, input logic [7:0] es, input logic ec, input bit poke);
    int k = 1;
    int busy_cnt = 0;
    while (!done8 && k < 20) begin
      if (busy8) busy_cnt++;
      if (poke && k == 3) begin
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
      end else if (poke && k == 4) begin
        start8 = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    check({tag, "_latency"}, 32'(k), 32'd9);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
    check({tag, "_sum"}, 32'(sum8), 32'(es));
    check({tag, "_cout"}, 32'(cout8), 32'(ec));
  endtask

  task automatic do4(input logic [3:0] a, input logic [3:0] b, input logic c);
    logic [4:0] exp;
    int k = 1;
    int busy_cnt = 0;
    exp = 5'(a) + 5'(b) + 5'(c);
    a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    while (!done4 && k < 20) begin
      if (busy4) busy_cnt++;
      @(negedge clk);
      k++;
    end
    check("n4_latency", 32'(k), 32'd5);
    check("n4_busy_cycles", 32'(busy_cnt), 32'd4);
    check("n4_result", 32'({cout4, sum4}), 32'(exp));
    @(negedge clk);
    check("n4_done_width", 32'(done4), 32'd0);
    check("n4_idle_hold", 32'({cout4, sum4}), 32'(exp));
  endtask

  initial begin
    int done_seen;
    rst_n = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;

    // Asynchronous reset in the middle of a cycle.
    #13 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_sum", 32'(sum8), 32'h00);
    check("rst_cout", 32'(cout8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    launch8(8'h05, 8'h03, 1'b0);
    finish8("add_05_03", 8'h08, 1'b0, 1'b0);
    @(negedge clk);
    check("done_width", 32'(done8), 32'd0);
    check("idle_hold_sum", 32'(sum8), 32'h08);

    launch8(8'hFF, 8'h01, 1'b0);
    check("run_hold_sum", 32'(sum8), 32'h08);
    finish8("add_ff_01", 8'h00, 1'b1, 1'b0);
    @(negedge clk);

    launch8(8'hFF, 8'hFF, 1'b1);
    finish8("add_ff_ff_1", 8'hFF, 1'b1, 1'b0);
    @(negedge clk);

    // Start pulsed mid-RUN with other operands must be ignored.
    launch8(8'h05, 8'h03, 1'b0);
    finish8("busy_start", 8'h08, 1'b0, 1'b1);

    // Back-to-back start issued while done is high.
    launch8(8'h7F, 8'h01, 1'b0);
    check("b2b_hold_sum", 32'(sum8), 32'h08);
    finish8("b2b_7f_01", 8'h80, 1'b0, 1'b0);
    @(negedge clk);

    // Abort after four RUN edges.
    launch8(8'h33, 8'h44, 1'b0);
    repeat (4) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_sum", 32'(sum8), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    check("abort_sum_after", 32'({cout8, sum8}), 32'h000);

    launch8(8'h01, 8'h01, 1'b1);
    finish8("add_01_01_1", 8'h03, 1'b0, 1'b0);
    @(negedge clk);

    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++)
          do4(4'(ia), 4'(ib), 1'(ic));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
